// File: rtl/irda_pkg.sv
// irda_pkg: register map, bit indices, TX FSM states and reset constants for the IrDA FIFO peripheral
package irda_pkg;
  localparam logic [3:0] REG_RXDATA = 4'h0;
  localparam logic [3:0] REG_TXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CONTROL = 4'hC;
  localparam int ST_RX_NE = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL = 3;
  localparam int ST_TX_ACTIVE = 4;
  localparam int ST_RX_OVF = 5;
  localparam int ST_TX_OVF = 6;
  localparam int CT_RX_EN = 0;
  localparam int CT_TX_EN = 1;
  localparam int CT_IRQ_RX_EN = 2;
  localparam int CT_IRQ_TXE_EN = 3;
  localparam int CT_RX_FLUSH = 4;
  localparam int CT_TX_FLUSH = 5;
  localparam int CT_LOOPBACK = 6;
  localparam logic [7:0] CONTROL_RESET = 8'h03;
  typedef enum logic [1:0] {IDLE, LOAD, START, SEND} txState_t;
endpackage

// File: rtl/irda_sync_fifo.sv
// irda_sync_fifo: show-ahead synchronous FIFO with flush; push on full succeeds only alongside a pop
module irda_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             iCLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic doPush, doPop;
  assign empty = count == '0;
  assign full = count[AW];
  assign head = mem[rp];
  assign doPop = pop & ~empty;
  assign doPush = push & (~full | doPop);
  always_ff @(posedge iCLK)
    if (doPush & ~flush) mem[wp] <= din;
  always_ff @(posedge iCLK) begin
    if (Reset | flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (doPush) wp <= wp + 1'b1;
      if (doPop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end
endmodule

// File: rtl/irda_fifo_interface.sv
// irda_fifo_interface: memory-mapped IrDA peripheral with RX/TX FIFOs, transmitter handshake FSM and level IRQ
// Define IRDA_LOOPBACK_EN to add the CONTROL[6] loopback path from the TX FSM into the RX FIFO.
module irda_fifo_interface
  import irda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0500,
  parameter int DATA_WIDTH = 32,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic                  iCLK,
  input  logic                  Reset,
  input  logic                  wReadEnable,
  input  logic                  wWriteEnable,
  input  logic [3:0]            wByteEnable,
  input  logic [31:0]           wAddress,
  input  logic [31:0]           wWriteData,
  output logic [31:0]           wReadData,
  input  logic                  iRX_VALID,
  input  logic [DATA_WIDTH-1:0] iRX_DATA,
  output logic [DATA_WIDTH-1:0] oTX_DATA,
  output logic                  oTX_START,
  input  logic                  iTX_BUSY,
  output logic                  oIRQ
);
  localparam int RW = $clog2(RX_DEPTH) + 1;
  localparam int TW = $clog2(TX_DEPTH) + 1;
`ifdef IRDA_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'h4F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif
  logic hit, rd, wr, ctrlWr, statWr, txPush, rxPop, rxFlush, txFlush;
  logic [3:0] off;
  logic [7:0] ctrl;
  logic rxPush, rxFull, rxEmpty, txFull, txEmpty, txActive, load;
  logic [DATA_WIDTH-1:0] rxDin, rxHead, txHead, rxDataQ;
  logic [RW-1:0] rxCount;
  logic [TW-1:0] txCount;
  logic rxQ, rxQ2, extPush, rxOvf, txOvf;
  logic [31:0] status, regVal;
  txState_t state, stateNext;
  assign off = wAddress[3:0];
  assign hit = wAddress[31:4] == BASE_ADDRESS[31:4] && wAddress[1:0] == 2'b00;
  assign rd = wReadEnable & hit;
  assign wr = wWriteEnable & hit;
  assign ctrlWr = wr & off == REG_CONTROL & wByteEnable[0];
  assign statWr = wr & off == REG_STATUS & wByteEnable[0];
  assign txPush = wr & off == REG_TXDATA & wByteEnable == 4'hF;
  assign rxPop = rd & off == REG_RXDATA;
  assign rxFlush = ctrlWr & wWriteData[CT_RX_FLUSH];
  assign txFlush = ctrlWr & wWriteData[CT_TX_FLUSH];
  assign extPush = rxQ & ~rxQ2 & ctrl[CT_RX_EN];
`ifdef IRDA_LOOPBACK_EN
  assign rxPush = ctrl[CT_LOOPBACK] ? state == START & iTX_BUSY : extPush;
  assign rxDin = ctrl[CT_LOOPBACK] ? oTX_DATA : rxDataQ;
`else
  assign rxPush = extPush;
  assign rxDin = rxDataQ;
`endif
  irda_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) rxFifo (
    .iCLK(iCLK), .Reset(Reset), .push(rxPush), .pop(rxPop), .flush(rxFlush), .din(rxDin),
    .head(rxHead), .full(rxFull), .empty(rxEmpty), .count(rxCount)
  );
  irda_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) txFifo (
    .iCLK(iCLK), .Reset(Reset), .push(txPush), .pop(load), .flush(txFlush), .din(wWriteData[DATA_WIDTH-1:0]),
    .head(txHead), .full(txFull), .empty(txEmpty), .count(txCount)
  );
  always_comb begin
    load = state == IDLE & ctrl[CT_TX_EN] & ~txEmpty;
    stateNext = state == IDLE ? (load ? LOAD : IDLE) :
                state == LOAD ? START :
                state == START ? (iTX_BUSY ? SEND : START) :
                (iTX_BUSY ? SEND : IDLE);
    oTX_START = state == START;
    txActive = state != IDLE;
  end
  always_ff @(posedge iCLK)
    state <= Reset ? IDLE : stateNext;
  // Receive edge detector is a registered stage, so data and level are captured together.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      oTX_DATA <= '0;
      ctrl <= CONTROL_RESET;
      rxQ <= 1'b0;
      rxQ2 <= 1'b0;
      rxDataQ <= '0;
      rxOvf <= 1'b0;
      txOvf <= 1'b0;
      oIRQ <= 1'b0;
    end else begin
      if (load) oTX_DATA <= txHead;
      if (ctrlWr) ctrl <= wWriteData[7:0] & CTRL_MASK;
      rxQ <= iRX_VALID;
      rxQ2 <= rxQ;
      rxDataQ <= iRX_DATA;
      rxOvf <= (rxPush & rxFull & ~rxPop & ~rxFlush) | (rxOvf & ~(statWr & wWriteData[ST_RX_OVF]));
      txOvf <= (txPush & txFull & ~txFlush) | (txOvf & ~(statWr & wWriteData[ST_TX_OVF]));
      oIRQ <= (ctrl[CT_IRQ_RX_EN] & ~rxEmpty) | (ctrl[CT_IRQ_TXE_EN] & txEmpty & ~txActive);
    end
  end
  always_comb begin
    status = '0;
    status[ST_RX_NE] = ~rxEmpty;
    status[ST_RX_FULL] = rxFull;
    status[ST_TX_EMPTY] = txEmpty;
    status[ST_TX_FULL] = txFull;
    status[ST_TX_ACTIVE] = txActive;
    status[ST_RX_OVF] = rxOvf;
    status[ST_TX_OVF] = txOvf;
    status[15:8] = 8'(rxCount);
    status[23:16] = 8'(txCount);
    regVal = off == REG_RXDATA ? (rxEmpty ? '0 : 32'(rxHead)) :
             off == REG_STATUS ? status :
             off == REG_CONTROL ? {24'd0, ctrl} : '0;
  end
  assign wReadData = rd ? regVal : 'z;
endmodule
